if_fetch: RTL and testbench

//  RV32I instruction-fetch stage: the producer end of the decoder's pc_i/inst_i input.
//  - Holds the PC.
//  - Fetches each 32-bit instruction as four byte reads from the 8-bit memory port.
//  - Assembles the bytes little-endian and presents {pc_o, inst_o} to the decode stage

---
 rtl/if_fetch_if.sv | 32 +++
 rtl/if_fetch.sv | 146 ++++++++++++++
 tb/tb_if_fetch.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: byte-wide memory read port, redirect input from
// execute, and the {pc, inst} presentation toward decode.
// Handshakes:
//   memory : a byte moves at a rising edge where mem_req_o=1 and mem_rvalid_i=1;
//            mem_addr_o is stable while mem_req_o=1 and the byte is not taken.
//   decode : an instruction moves at a rising edge where inst_valid_o=1 and
//            stall_i=0 (and no redirect in that cycle); pc_o/inst_o are stable
//            while inst_valid_o=1 and stall_i=1.
interface if_fetch_if #(parameter int ADDR_W = 32);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_rvalid_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              stall_i;
  logic [ADDR_W-1:0] pc_o;
  logic [31:0]       inst_o;
  logic              inst_valid_o;

  // Fetch stage side
  modport master (
    output mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o,
    input  mem_rdata_i, mem_rvalid_i, branch_i, branch_target_i, stall_i
  );

  // Memory / decode / execute side
  modport slave (
    input  mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o,
    output mem_rdata_i, mem_rvalid_i, branch_i, branch_target_i, stall_i
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction fetch: reads each instruction as four little-endian bytes
// from an 8-bit memory port, presents {pc, inst} to decode, and takes
// redirects from execute (redirect beats everything else).
// Optional macro IF_PERF_CNT_EN adds perf_fetch_o / perf_stall_o counters.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_if.master  bus,
  output logic [2:0]  dbg_state_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o
`endif
);

  typedef enum logic [2:0] {
    S_B0   = 3'd0,
    S_B1   = 3'd1,
    S_B2   = 3'd2,
    S_B3   = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [23:0]       asm_q, asm_d;
  logic              inst_valid_q, inst_valid_d;
  logic [1:0]        byte_k;
  logic              fetching;

  // Byte index within the word is implied by the fetch state
  always_comb begin
    byte_k   = 2'd0;
    fetching = 1'b1;
    case (state_q)
      S_B0:    byte_k = 2'd0;
      S_B1:    byte_k = 2'd1;
      S_B2:    byte_k = 2'd2;
      S_B3:    byte_k = 2'd3;
      default: fetching = 1'b0;
    endcase
  end

  assign bus.mem_req_o    = rst & fetching;
  assign bus.mem_addr_o   = pc_q + {{(ADDR_W-2){1'b0}}, byte_k};
  assign bus.pc_o         = pc_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_valid_o = inst_valid_q;
  assign dbg_state_o      = state_q;

  // Next state: redirect first, then byte collection or decode handoff
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    asm_d        = asm_q;
    inst_valid_d = inst_valid_q;
    if (bus.branch_i) begin
      // Partial bytes and any byte arriving now are dropped
      pc_d         = bus.branch_target_i & ~ADDR_W'(3);
      inst_valid_d = 1'b0;
      state_d      = S_B0;
    end else begin
      case (state_q)
        S_B0: if (bus.mem_rvalid_i) begin
          asm_d[7:0] = bus.mem_rdata_i;
          state_d    = S_B1;
        end
        S_B1: if (bus.mem_rvalid_i) begin
          asm_d[15:8] = bus.mem_rdata_i;
          state_d     = S_B2;
        end
        S_B2: if (bus.mem_rvalid_i) begin
          asm_d[23:16] = bus.mem_rdata_i;
          state_d      = S_B3;
        end
        S_B3: if (bus.mem_rvalid_i) begin
          inst_d       = {bus.mem_rdata_i, asm_q};
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end
        S_HOLD: if (!bus.stall_i) begin
          pc_d         = pc_q + ADDR_W'(4);
          inst_valid_d = 1'b0;
          state_d      = S_B0;
        end
        default: begin
          inst_valid_d = 1'b0;
          state_d      = S_B0;
        end
      endcase
    end
  end

  // State, PC and instruction registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_B0;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      asm_q        <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      asm_q        <= asm_d;
      inst_valid_q <= inst_valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count completed transfers and stalled HOLD cycles
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (state_q == S_HOLD && !bus.stall_i && !bus.branch_i)
      perf_fetch_d = perf_fetch_q + 32'd1;
    if (state_q == S_HOLD && bus.stall_i)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by random memory latency,
// stalls and redirects, checked against a transaction-level model of the
// fetch stage (expected PC, bytes taken so far, presented word).
module tb_if_fetch;
  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  if_fetch_if #(.ADDR_W(32)) bus ();

  if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_o(perf_fetch),
    .perf_stall_o(perf_stall)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] exp_pc;
  int          exp_k;
  logic        exp_valid;
  logic [31:0] exp_inst;
  logic [31:0] exp_fetch;
  logic [31:0] exp_stall;

  // Memory contents: word 0 is addi x0,x0,0 (13 00 00 00), elsewhere a hash
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc    = 32'h0;
    exp_k     = 0;
    exp_valid = 1'b0;
    exp_inst  = 32'h0;
    exp_fetch = 32'h0;
    exp_stall = 32'h0;
  endtask

  // Hold reset for n edges, checking outputs while asserted
  task automatic do_reset(input int n);
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 8'($urandom);
    bus.branch_i     = 1'b0;
    bus.stall_i      = 1'b0;
    #1;
    check1("rst_req_comb", bus.mem_req_o, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check1("rst_req", bus.mem_req_o, 1'b0);
      check1("rst_valid", bus.inst_valid_o, 1'b0);
      check32("rst_pc", bus.pc_o, 32'h0);
      check32("rst_inst", bus.inst_o, 32'h0);
`ifdef IF_PERF_CNT_EN
      check32("rst_perf_fetch", perf_fetch, 32'h0);
      check32("rst_perf_stall", perf_stall, 32'h0);
`endif
    end
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  // One clock: drive inputs, compare outputs to the model, advance the model
  task automatic cycle(input logic br, input logic [31:0] tgt, input logic st, input logic rv);
    bus.branch_i        = br;
    bus.branch_target_i = tgt;
    bus.stall_i         = st;
    bus.mem_rvalid_i    = rv;
    bus.mem_rdata_i     = rv ? mem_byte(bus.mem_addr_o) : 8'($urandom);
    #1;
    check1("req", bus.mem_req_o, !exp_valid);
    if (!exp_valid) check32("addr", bus.mem_addr_o, exp_pc + 32'(exp_k));
    check1("valid", bus.inst_valid_o, exp_valid);
    check32("pc", bus.pc_o, exp_pc);
    check32("inst", bus.inst_o, exp_inst);
`ifdef IF_PERF_CNT_EN
    check32("perf_fetch", perf_fetch, exp_fetch);
    check32("perf_stall", perf_stall, exp_stall);
`endif
    if (exp_valid && st) exp_stall = exp_stall + 32'd1;
    if (exp_valid && !st && !br) exp_fetch = exp_fetch + 32'd1;
    if (br) begin
      exp_pc    = tgt & ~32'd3;
      exp_k     = 0;
      exp_valid = 1'b0;
    end else if (exp_valid) begin
      if (!st) begin
        exp_pc    = exp_pc + 32'd4;
        exp_k     = 0;
        exp_valid = 1'b0;
      end
    end else if (rv) begin
      exp_k++;
      if (exp_k == 4) begin
        exp_inst  = mem_word(exp_pc);
        exp_valid = 1'b1;
        exp_k     = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst                 = 1'b0;
    bus.mem_rdata_i     = 8'h00;
    bus.mem_rvalid_i    = 1'b0;
    bus.branch_i        = 1'b0;
    bus.branch_target_i = 32'h0;
    bus.stall_i         = 1'b0;
    model_reset();
    do_reset(2);

    // Scenario 1: first word from reset, bytes 13 00 00 00
    for (int i = 0; i < 4; i++) begin
      check32("t1_addr", bus.mem_addr_o, 32'(i));
      check1("t1_req", bus.mem_req_o, 1'b1);
      check1("t1_notvalid", bus.inst_valid_o, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
    end
    check1("t1_valid", bus.inst_valid_o, 1'b1);
    check32("t1_inst", bus.inst_o, 32'h0000_0013);
    check32("t1_pc", bus.pc_o, 32'h0);

    // Scenario 2: three stalled HOLD cycles, then release
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      check1("t2_hold_valid", bus.inst_valid_o, 1'b1);
      check32("t2_hold_pc", bus.pc_o, 32'h0);
      check32("t2_hold_inst", bus.inst_o, 32'h0000_0013);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check32("t2_pc_next", bus.pc_o, 32'h4);
    check32("t2_addr_next", bus.mem_addr_o, 32'h4);
    repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Scenario 3: two empty cycles on byte 2 of pc=8
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check32("t3_addr_wait", bus.mem_addr_o, 32'd10);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
    end
    check32("t3_addr_wait", bus.mem_addr_o, 32'd10);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check1("t3_valid", bus.inst_valid_o, 1'b1);
    check32("t3_inst", bus.inst_o, mem_word(32'd8));
    check32("t3_pc", bus.pc_o, 32'd8);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Scenario 4: redirect to 0x103 during byte 1 of pc=12
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h103, 1'b0, 1'b1);
    check32("t4_addr", bus.mem_addr_o, 32'h100);
    check1("t4_valid", bus.inst_valid_o, 1'b0);
    check32("t4_inst_old", bus.inst_o, mem_word(32'd8));
    repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check32("t4_inst", bus.inst_o, mem_word(32'h100));

    // Scenario 5: redirect to 0x40 exactly when the held word would transfer
    cycle(1'b1, 32'h40, 1'b0, 1'b1);
    check32("t5_pc", bus.pc_o, 32'h40);
    check1("t5_valid", bus.inst_valid_o, 1'b0);
`ifdef IF_PERF_CNT_EN
    check32("t5_perf_fetch", perf_fetch, 32'd3);
    check32("t5_perf_stall", perf_stall, 32'd3);
`endif

    // Address wrap: redirect near the top of the address space
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
    check32("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      check32("wrap_addr", bus.mem_addr_o, 32'hFFFF_FFFC + 32'(i));
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
    end
    check32("wrap_inst", bus.inst_o, mem_word(32'hFFFF_FFFC));
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check32("wrap_pc_next", bus.pc_o, 32'h0);
    check32("wrap_addr_next", bus.mem_addr_o, 32'h0);

    // Scenario 6: reset while collecting byte 2
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check32("t6_addr_b2", bus.mem_addr_o, 32'd2);
    do_reset(1);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      logic        br;
      logic        st;
      logic        rv;
      logic [31:0] tgt;
      br  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 2) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom);
      cycle(br, tgt, st, rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
